// File: rtl/rv32i_mmio_timer_if.sv
// CPU data-port view of the timer's register window: store strobe, address,
// store data, and the combinational select/read-data returned to the read mux.
interface rv32i_mmio_timer_if;
  logic        Memwrite;
  logic [31:0] Memaddr;
  logic [31:0] MemWdata;
  logic        sel;
  logic [31:0] rdata;

  modport master (
    output Memwrite,
    output Memaddr,
    output MemWdata,
    input  sel,
    input  rdata
  );

  modport slave (
    input  Memwrite,
    input  Memaddr,
    input  MemWdata,
    output sel,
    output rdata
  );
endinterface

// File: rtl/rv32i_mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, overflow flag and
// a registered level interrupt, sitting on the RV32I data port.
module rv32i_mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_2000,
  parameter int          PRESC_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  rv32i_mmio_timer_if.slave   bus,
  output logic                irq
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  logic [2:0]         ctrl_q,   ctrl_d;
  logic [PRESC_W-1:0] presc_q,  presc_d;
  logic [PRESC_W-1:0] pcnt_q,   pcnt_d;
  logic [31:0]        count_q,  count_d;
  logic [31:0]        cmp_q,    cmp_d;
  logic [1:0]         status_q, status_d;
  logic               irq_q,    irq_d;

  logic       wr;
  logic [2:0] off;
  logic       wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
  logic       tick;
  logic       hit;
  logic [1:0] status_set, status_clr;
  logic       addr_lsb_unused;

  // Byte-lane bits are irrelevant: only full-word accesses exist.
  assign addr_lsb_unused = ^bus.Memaddr[1:0];

  assign bus.sel = (bus.Memaddr[31:5] == BASE_ADDR[31:5]);
  assign wr      = bus.sel & bus.Memwrite;
  assign off     = bus.Memaddr[4:2];

  always_comb begin
    wr_ctrl   = wr && (off == OFF_CTRL);
    wr_presc  = wr && (off == OFF_PRESC);
    wr_count  = wr && (off == OFF_COUNT);
    wr_cmp    = wr && (off == OFF_CMP);
    wr_status = wr && (off == OFF_STATUS);
  end

  always_comb begin
    ctrl_d     = wr_ctrl  ? bus.MemWdata[2:0]         : ctrl_q;
    presc_d    = wr_presc ? bus.MemWdata[PRESC_W-1:0] : presc_q;
    cmp_d      = wr_cmp   ? bus.MemWdata              : cmp_q;
    tick       = ctrl_q[0] && (pcnt_q == presc_q);
    hit        = (count_q == cmp_q);
    pcnt_d     = pcnt_q + PRESC_W'(1);
    count_d    = count_q;
    status_set = 2'b00;
    status_clr = wr_status ? bus.MemWdata[1:0] : 2'b00;

    // Reconfiguring the timing restarts the prescale period from zero.
    if (!ctrl_q[0] || wr_ctrl || wr_presc || tick) begin
      pcnt_d = '0;
    end

    if (tick) begin
      if (hit) begin
        status_set[0] = 1'b1;
      end
      if (hit && ctrl_q[1]) begin
        count_d = '0;
      end else begin
        count_d = count_q + 32'd1;
        if (count_q == 32'hFFFF_FFFF) begin
          status_set[1] = 1'b1;
        end
      end
    end

    // A CPU store to COUNT overrides whatever the tick computed.
    if (wr_count) begin
      count_d = bus.MemWdata;
    end

    irq_d = ctrl_q[2] & (|status_q);
  end

  // Hardware set wins over a write-1-to-clear in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_flag
      assign status_d[gi] = status_set[gi] | (status_q[gi] & ~status_clr[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      count_q  <= '0;
      cmp_q    <= 32'hFFFF_FFFF;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    bus.rdata = 32'd0;
    if (bus.sel) begin
      case (off)
        OFF_CTRL:   bus.rdata = {29'd0, ctrl_q};
        OFF_PRESC:  bus.rdata = 32'(presc_q);
        OFF_COUNT:  bus.rdata = count_q;
        OFF_CMP:    bus.rdata = cmp_q;
        OFF_STATUS: bus.rdata = {30'd0, status_q};
        default:    bus.rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mmio_timer.sv
// Self-checking bench for rv32i_mmio_timer: directed scenarios plus a random
// register-traffic phase, all checked against a cycle-level behavioural model.
module tb_rv32i_mmio_timer;

  localparam logic [31:0] BASE     = 32'hFFFF_2000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_PRESC  = BASE + 32'h04;
  localparam logic [31:0] A_COUNT  = BASE + 32'h08;
  localparam logic [31:0] A_CMP    = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS = BASE + 32'h10;
  localparam logic [31:0] PMASK    = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  logic irq;

  rv32i_mmio_timer_if bus ();

  rv32i_mmio_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] obs_rdata;
  logic        obs_sel;
  logic        obs_irq;

  // Behavioural model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_presc, m_pcnt, m_count, m_cmp;
  logic        m_match, m_ovf, m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic in_win(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  task automatic m_reset();
    m_ctrl = 0; m_presc = 0; m_pcnt = 0; m_count = 0;
    m_cmp = 32'hFFFF_FFFF; m_match = 0; m_ovf = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!in_win(a)) return 32'd0;
    case (a[4:2])
      3'd0: return {29'd0, m_ctrl};
      3'd1: return m_presc;
      3'd2: return m_count;
      3'd3: return m_cmp;
      3'd4: return {30'd0, m_ovf, m_match};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the timer, computed from the register-level rules.
  task automatic m_step(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic w, en, tick, set_m, set_o;
    int o;
    logic [31:0] nc, np;
    w = we && in_win(a);
    o = int'(a[4:2]);
    en = m_ctrl[0];
    tick = en && (m_pcnt == m_presc);
    set_m = 0; set_o = 0;
    nc = m_count;
    if (tick) begin
      if (m_count == m_cmp) set_m = 1;
      if (m_count == m_cmp && m_ctrl[1]) nc = 0;
      else begin
        if (m_count == 32'hFFFF_FFFF) set_o = 1;
        nc = m_count + 1;
      end
    end
    if (!en || (w && (o == 0 || o == 1)) || tick) np = 0;
    else np = m_pcnt + 1;
    m_irq = m_ctrl[2] && (m_match || m_ovf);
    m_match = set_m || (m_match && !(w && o == 4 && d[0]));
    m_ovf   = set_o || (m_ovf   && !(w && o == 4 && d[1]));
    if (w && o == 2) nc = d;
    if (w && o == 0) m_ctrl = d[2:0];
    if (w && o == 1) m_presc = d & PMASK;
    if (w && o == 3) m_cmp = d;
    m_count = nc;
    m_pcnt = np;
  endtask

  // One bus cycle: drive, check combinational read, clock, check irq.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.Memwrite = we; bus.Memaddr = a; bus.MemWdata = d;
    #1;
    obs_rdata = bus.rdata;
    obs_sel   = bus.sel;
    chk("sel", {31'd0, obs_sel}, {31'd0, in_win(a)});
    chk("rdata", obs_rdata, m_read(a));
    @(posedge clk);
    m_step(we, a, d);
    #1;
    obs_irq = irq;
    chk("irq", {31'd0, obs_irq}, {31'd0, m_irq});
    $display("cyc t=%0t we=%0d addr=%08h wdata=%08h rdata=%08h irq=%0d",
             $time, we, a, d, obs_rdata, obs_irq);
    @(negedge clk);
  endtask

  // Assert reset between edges and confirm state clears before the next edge.
  task automatic async_rst();
    bus.Memwrite = 0; bus.Memaddr = A_COUNT; bus.MemWdata = 0;
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_count", bus.rdata, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    bus.Memaddr = A_STATUS;
    #1;
    chk("arst_status", bus.rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset pulse done t=%0t", $time);
  endtask

  initial begin
    logic [31:0] a, d;
    int r, o;
    rst_n = 1'b0;
    bus.Memwrite = 0; bus.Memaddr = 0; bus.MemWdata = 0;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset readback
    cyc(0, A_CTRL, 0);   chk("rst_ctrl",   obs_rdata, 32'd0);
    chk("rst_irq", {31'd0, obs_irq}, 32'd0);
    cyc(0, A_PRESC, 0);  chk("rst_presc",  obs_rdata, 32'd0);
    cyc(0, A_COUNT, 0);  chk("rst_count",  obs_rdata, 32'd0);
    cyc(0, A_CMP, 0);    chk("rst_cmp",    obs_rdata, 32'hFFFF_FFFF);
    cyc(0, A_STATUS, 0); chk("rst_status", obs_rdata, 32'd0);
    cyc(0, BASE + 32'h18, 0); chk("rsvd_rd", obs_rdata, 32'd0);
    cyc(0, 32'h0000_1008, 0);
    chk("out_sel", {31'd0, obs_sel}, 32'd0);
    chk("out_rdata", obs_rdata, 32'd0);

    // Prescale by 4: COUNT reaches 5 twenty clocks after enabling
    cyc(1, A_PRESC, 3);
    cyc(1, A_CTRL, 1);
    for (int i = 1; i <= 21; i++) begin
      cyc(0, A_COUNT, 0);
      if (i == 20) chk("presc_c4", obs_rdata, 32'd4);
      if (i == 21) chk("presc_c5", obs_rdata, 32'd5);
    end

    // Auto-reload match at 9
    cyc(1, A_CTRL, 0); cyc(1, A_PRESC, 0); cyc(1, A_COUNT, 0);
    cyc(1, A_CMP, 9);  cyc(1, A_STATUS, 3); cyc(1, A_CTRL, 7);
    for (int i = 1; i <= 11; i++) begin
      cyc(0, A_COUNT, 0);
      chk("auto_seq", obs_rdata, 32'((i - 1) % 10));
    end
    cyc(0, A_STATUS, 0);
    chk("auto_match", obs_rdata, 32'd1);
    chk("auto_irq", {31'd0, obs_irq}, 32'd1);
    cyc(1, A_STATUS, 1);
    chk("w1c_irq_hold", {31'd0, obs_irq}, 32'd1);
    cyc(0, A_STATUS, 0);
    chk("w1c_cleared", obs_rdata, 32'd0);
    chk("w1c_irq_low", {31'd0, obs_irq}, 32'd0);
    for (int i = 0; i < 6; i++) cyc(0, A_COUNT, 0);
    cyc(0, A_STATUS, 0);
    chk("rematch", obs_rdata, 32'd1);

    // Overflow then match at 0
    cyc(1, A_CTRL, 0); cyc(1, A_STATUS, 3); cyc(1, A_PRESC, 0);
    cyc(1, A_COUNT, 32'hFFFF_FFFE); cyc(1, A_CMP, 0); cyc(1, A_CTRL, 5);
    cyc(0, A_COUNT, 0); chk("ovf_c0", obs_rdata, 32'hFFFF_FFFE);
    cyc(0, A_COUNT, 0); chk("ovf_c1", obs_rdata, 32'hFFFF_FFFF);
    cyc(0, A_COUNT, 0); chk("ovf_c2", obs_rdata, 32'd0);
    cyc(0, A_STATUS, 0); chk("ovf_flags", obs_rdata, 32'd3);

    // COUNT write on a tick cycle
    cyc(1, A_COUNT, 32'h100);
    cyc(0, A_COUNT, 0); chk("wr_beats_tick", obs_rdata, 32'h100);

    // W1C on the match tick
    cyc(1, A_CTRL, 0); cyc(1, A_STATUS, 3); cyc(1, A_COUNT, 5);
    cyc(1, A_CMP, 6);  cyc(1, A_CTRL, 1);
    cyc(0, A_COUNT, 0);
    cyc(1, A_STATUS, 1);
    cyc(0, A_STATUS, 0); chk("set_beats_w1c", obs_rdata, 32'd1);

    // Async reset while counting with irq high
    cyc(1, A_CTRL, 5);
    cyc(0, A_COUNT, 0);
    cyc(0, A_COUNT, 0);
    chk("pre_rst_irq", {31'd0, obs_irq}, 32'd1);
    async_rst();
    cyc(0, A_CTRL, 0); chk("post_rst_ctrl", obs_rdata, 32'd0);

    // Random register traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      o = $urandom_range(0, 7);
      a = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = $urandom;
      case (o)
        0: d = $urandom_range(0, 7) | ($urandom & 32'hFFFF_FFF8);
        1: d = $urandom_range(0, 3) | ($urandom & 32'hFFFF_0000);
        2: case ($urandom_range(0, 2))
             0: d = m_cmp - 32'($urandom_range(0, 6));
             1: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
             default: d = $urandom;
           endcase
        3: d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
        default: d = $urandom;
      endcase
      if (r == 0) async_rst();
      else cyc(r < 60, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
